lstm_gate_seq: RTL and testbench
================================

# lstm_gate_seq

Sequencer for one LSTM gate datapath: two MACs (x·w and h·u), a 3-input adder with bias, and a tanh/sigmoid activation. On a start pulse it walks the input vector (NUM_X elements) and the hidden vector (NUM_H elements) in parallel. It drives operand-memory addresses, MAC accumulate controls and operand-enable strobes, then pulses `o_valid` when the activation output is stable. It sits between the layer-level scheduler and each gate instance.

## Interface
- `NUM_X`, default 4: input-vector length; must be ≥1.
- `NUM_H`, default 4: hidden-vector length; must be ≥1.
- `LAT`, default 1: cycles from the last operand cycle to a valid activation output; must be ≥1.
- `AW_X`, default `$clog2(NUM_X)` (min 1): width of the x/w address.
- `AW_H`, default `$clog2(NUM_H)` (min 1): width of the h/u address.

- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `i_start`, in, 1: request one gate evaluation; one-cycle pulse.
- `i_hold`, in, 1: operand stall; freezes the ACC state.
- `o_addr_x`, out, AW_X: index into the x and w memories.
- `o_addr_h`, out, AW_H: index into the h and u memories.
- `o_acc_x`, out, 1: drives the x-MAC `acc` (0 = load product, 1 = accumulate).
- `o_acc_h`, out, 1: drives the h-MAC `acc`.
- `o_en_x`, out, 1: x operand valid; when low, the datapath muxes 0 into `i_x`.
- `o_en_h`, out, 1: h operand valid; when low, the datapath muxes 0 into `i_h`.
- `o_busy`, out, 1: high while an evaluation is in progress.
- `o_valid`, out, 1: one-cycle pulse; the activation output is valid this cycle.

## Operation
- States:
  - IDLE: wait for `i_start`.
  - ACC: one operand cycle per element index.
  - WAIT: LAT cycles for the datapath to settle.
- IDLE → ACC when `i_start`=1. `i_start` in ACC or in a non-final WAIT cycle is ignored.
- ACC: run N = max(NUM_X, NUM_H) unstalled cycles with element index i = 0..N-1.
  - `o_addr_x` = i while i < NUM_X, otherwise it holds NUM_X-1. `o_addr_h` follows the same rule with NUM_H.
  - `o_en_x` = (i < NUM_X). `o_en_h` = (i < NUM_H).
  - `o_acc_x` = `o_acc_h` = 0 at i=0, which loads and clears the accumulators; both are 1 for i ≥ 1.
  - The shorter vector keeps accumulating zero operands, so its sum is preserved.
- `i_hold`=1 in ACC:
  - The index and addresses freeze.
  - `o_en_x` = `o_en_h` = 0 and `o_acc_*` = 1, so the accumulators hold.
  - If hold lands on i=0, the i=0 cycle (acc=0, en=1) is issued when hold releases. The accumulators do not start until then.
- ACC → WAIT after the i=N-1 cycle completes unstalled.
- WAIT: `o_en_*` = 0 and `o_acc_*` = 1, so results are stable. A down-counter runs LAT cycles. `o_valid`=1 in the final WAIT cycle. `i_hold` is ignored in WAIT.
- Final WAIT cycle:
  - With `i_start`=1: go straight to ACC at i=0 (back-to-back, no IDLE bubble).
  - Otherwise: go to IDLE.
- IDLE: `o_en_*` = 0, `o_acc_*` = 1, addresses = 0. The last result stays on the datapath.
- `o_busy` = 1 in ACC and WAIT.
- NUM_X = NUM_H = 1: ACC lasts one cycle with acc=0, so `o_acc_*` is never 1 during ACC.

## Timing
- All outputs are registered and change only on the rising edge of `clk`.
- Reset values: state IDLE, every output 0 (`o_acc_*` = 0). The first cycle after reset release drives IDLE values.
- `rst` asserted mid-operation: immediate return to IDLE. No `o_valid` is produced, and the partial accumulation is abandoned.
- Latency with `i_start` sampled at edge k and no stalls:
  - ACC occupies cycles k+1 … k+N.
  - WAIT occupies cycles k+N+1 … k+N+LAT.
  - `o_valid` is high in cycle k+N+LAT.
- Each `i_hold` cycle in ACC adds exactly 1 cycle to this latency.
- Throughput with back-to-back starts: one result every N+LAT cycles.

## Structure
- Shared package `lstm_pkg` holds:
  - the state typedef `gate_state_t` (IDLE, ACC, WAIT);
  - the helper function `max_len`;
  - the shared default widths (`WIDTH`=32, `FRAC`=24), so the sequencer and the gate agree.
- One sub-module, `idx_counter`: a parameterised up-counter with hold, terminal-count flag and saturation at MAX-1. It is instantiated for i, and reused as the LAT down-counter (count direction as a parameter).

## Test plan
- NUM_X=4, NUM_H=3, LAT=1, start at edge 0, no hold:
  - `o_addr_x` = 0,1,2,3 and `o_addr_h` = 0,1,2,2 in cycles 1–4.
  - `o_en_h` = 1,1,1,0 and acc = 0,1,1,1.
  - `o_valid` in cycle 5; `o_busy` high in cycles 1–5.
- Same configuration with `i_hold` high in cycles 2–3: the address sequence stretches, `o_en_*` is 0 in cycles 2–3, and `o_valid` moves to cycle 7. With a gate datapath, all-ones vectors and bias 0, the pre-activation sum is 7.0 (Q8.24).
- Second `i_start` in the `o_valid` cycle: ACC restarts at i=0 next cycle with acc=0, and the next `o_valid` comes N+LAT cycles later.
- `i_start` pulsed in cycle 2 of ACC: ignored, exactly one `o_valid`.
- `rst` raised in cycle 3 of ACC: all outputs 0 at once and no `o_valid`. A later start completes normally.
- NUM_X = NUM_H = 1, LAT=3: one ACC cycle with acc=0 and en=1, then `o_valid` in cycle 4.

Source files
------------

// File: rtl/lstm_pkg.sv
// Shared types and constants for the LSTM gate sequencer and gate datapath.
package lstm_pkg;

  // Datapath word format shared by the sequencer and the gate (Q8.24).
  localparam int WIDTH = 32;
  localparam int FRAC  = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    WAIT = 2'd2
  } gate_state_t;

  // Number of operand cycles needed to walk both vectors in parallel.
  function automatic int max_len(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lstm_gate_seq_idx_counter.sv
// Saturating index counter with hold. An up-counter runs 0..MAX-1 and
// flags MAX-1. A down-counter loads MAX-1, runs down to 0 and flags 0.
// clr has priority over en. When neither is high, the count holds.
module idx_counter #(
  parameter int MAX  = 4,
  parameter bit DOWN = 1'b0,
  parameter int W    = (MAX > 1) ? $clog2(MAX) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);
  localparam logic [W-1:0] INIT = DOWN ? LAST : '0;

  logic [W-1:0] cnt_q;

  // Count register: load, step toward the terminal value, or hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= INIT;
    end else if (clr_i) begin
      cnt_q <= INIT;
    end else if (en_i) begin
      if (DOWN) begin
        if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      end else begin
        if (cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = DOWN ? (cnt_q == '0) : (cnt_q == LAST);

endmodule

// File: rtl/lstm_gate_seq.sv
// LSTM gate sequencer. It walks the x and h vectors in parallel and drives
// the operand addresses, the operand enables and the MAC accumulate controls.
// It then waits LAT cycles and pulses o_valid. Every output is registered.
// The values registered at an edge describe the cycle that follows it.
module lstm_gate_seq
  import lstm_pkg::*;
#(
  parameter int NUM_X = 4,
  parameter int NUM_H = 4,
  parameter int LAT   = 1,
  parameter int AW_X  = (NUM_X > 1) ? $clog2(NUM_X) : 1,
  parameter int AW_H  = (NUM_H > 1) ? $clog2(NUM_H) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_hold,
  output logic [AW_X-1:0] o_addr_x,
  output logic [AW_H-1:0] o_addr_h,
  output logic            o_acc_x,
  output logic            o_acc_h,
  output logic            o_en_x,
  output logic            o_en_h,
  output logic            o_busy,
  output logic            o_valid
);

  localparam int N  = max_len(NUM_X, NUM_H);
  localparam int CW = $clog2(N + 1);
  localparam int WW = (LAT > 1) ? $clog2(LAT) : 1;

  gate_state_t     state_q;
  logic [AW_X-1:0] addr_x_q;
  logic [AW_H-1:0] addr_h_q;
  logic            acc_x_q, acc_h_q, en_x_q, en_h_q, busy_q, valid_q;

  // c counts the elements already issued. It reaches N once every element
  // has gone out. w counts the WAIT cycles that remain after the current one.
  logic [CW-1:0] c;
  logic          c_tc, c_clr;
  logic [WW-1:0] w;
  logic          w_tc, w_clr, w_en;

  logic            go, acc_run, issue;
  logic            iss_en_x, iss_en_h, iss_acc;
  logic [AW_X-1:0] iss_addr_x;
  logic [AW_H-1:0] iss_addr_h;

  // Start is accepted in IDLE or in the final WAIT cycle (back-to-back).
  // An element is issued whenever one is pending and no stall is present.
  always_comb begin
    go      = i_start && ((state_q == IDLE) || ((state_q == WAIT) && w_tc));
    acc_run = (state_q == ACC) && !c_tc;
    issue   = (go || acc_run) && !i_hold;
    c_clr   = !issue && !acc_run;
    w_clr   = (state_q == ACC) && c_tc;
    w_en    = (state_q == WAIT) && !w_tc;
  end

  // Operand controls for element c. The shorter vector parks on its last
  // address with its enable low, so its MAC keeps adding zeros.
  always_comb begin
    iss_en_x   = c < CW'(NUM_X);
    iss_en_h   = c < CW'(NUM_H);
    iss_acc    = c != '0;
    iss_addr_x = iss_en_x ? AW_X'(c) : AW_X'(NUM_X - 1);
    iss_addr_h = iss_en_h ? AW_H'(c) : AW_H'(NUM_H - 1);
  end

  idx_counter #(.MAX(N + 1), .DOWN(1'b0), .W(CW)) u_idx (
    .clk   (clk),
    .rst   (rst),
    .clr_i (c_clr),
    .en_i  (issue),
    .cnt_o (c),
    .tc_o  (c_tc)
  );

  idx_counter #(.MAX(LAT), .DOWN(1'b1), .W(WW)) u_lat (
    .clk   (clk),
    .rst   (rst),
    .clr_i (w_clr),
    .en_i  (w_en),
    .cnt_o (w),
    .tc_o  (w_tc)
  );

  // FSM with registered outputs. A stall, or no operand pending, yields
  // en=0 and acc=1, which freezes both accumulators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_x_q <= '0;
      addr_h_q <= '0;
      acc_x_q  <= 1'b0;
      acc_h_q  <= 1'b0;
      en_x_q   <= 1'b0;
      en_h_q   <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      en_x_q  <= 1'b0;
      en_h_q  <= 1'b0;
      acc_x_q <= 1'b1;
      acc_h_q <= 1'b1;
      valid_q <= 1'b0;
      if (go || acc_run) begin
        state_q <= ACC;
        busy_q  <= 1'b1;
        if (!i_hold) begin
          addr_x_q <= iss_addr_x;
          addr_h_q <= iss_addr_h;
          en_x_q   <= iss_en_x;
          en_h_q   <= iss_en_h;
          acc_x_q  <= iss_acc;
          acc_h_q  <= iss_acc;
        end else if (go) begin
          addr_x_q <= '0;
          addr_h_q <= '0;
        end
      end else if (state_q == ACC) begin
        state_q <= WAIT;
        busy_q  <= 1'b1;
        valid_q <= (LAT == 1);
      end else if ((state_q == WAIT) && !w_tc) begin
        busy_q  <= 1'b1;
        valid_q <= (w == WW'(1));
      end else begin
        state_q  <= IDLE;
        busy_q   <= 1'b0;
        addr_x_q <= '0;
        addr_h_q <= '0;
      end
    end
  end

  assign o_addr_x = addr_x_q;
  assign o_addr_h = addr_h_q;
  assign o_acc_x  = acc_x_q;
  assign o_acc_h  = acc_h_q;
  assign o_en_x   = en_x_q;
  assign o_en_h   = en_h_q;
  assign o_busy   = busy_q;
  assign o_valid  = valid_q;

endmodule

// File: tb/tb_lstm_gate_seq.sv
// Bench for lstm_gate_seq. Two DUTs are instantiated: one with NUM_X=4,
// NUM_H=3 and LAT=1, and one with NUM_X=NUM_H=1 and LAT=3. Each table row
// gives the inputs applied before an edge and the outputs expected in the
// cycle after that edge. A behavioural MAC pair on DUT1 uses all-ones
// operands and checks the pre-activation sum at every o_valid.
module tb_lstm_gate_seq;

  localparam int          WIDTH = lstm_pkg::WIDTH;
  localparam int          FRAC  = lstm_pkg::FRAC;
  localparam logic [31:0] ONE   = 32'(1) << FRAC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       st1 = 1'b0, hd1 = 1'b0, st2 = 1'b0, hd2 = 1'b0;
  logic [1:0] ax1, ah1;
  logic       ex1, eh1, acx1, ach1, b1, v1;
  logic [0:0] ax2, ah2;
  logic       ex2, eh2, acx2, ach2, b2, v2;

  lstm_gate_seq #(.NUM_X(4), .NUM_H(3), .LAT(1)) dut1 (
    .clk(clk), .rst(rst), .i_start(st1), .i_hold(hd1),
    .o_addr_x(ax1), .o_addr_h(ah1), .o_acc_x(acx1), .o_acc_h(ach1),
    .o_en_x(ex1), .o_en_h(eh1), .o_busy(b1), .o_valid(v1)
  );

  lstm_gate_seq #(.NUM_X(1), .NUM_H(1), .LAT(3)) dut2 (
    .clk(clk), .rst(rst), .i_start(st2), .i_hold(hd2),
    .o_addr_x(ax2), .o_addr_h(ah2), .o_acc_x(acx2), .o_acc_h(ach2),
    .o_en_x(ex2), .o_en_h(eh2), .o_busy(b2), .o_valid(v2)
  );

  // MAC pair on DUT1. Each x, w, h and u operand is 1.0, so each product is 1.0.
  logic [WIDTH-1:0] sx, sh;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sx <= '0;
      sh <= '0;
    end else begin
      sx <= acx1 ? sx + (ex1 ? ONE : 32'd0) : (ex1 ? ONE : 32'd0);
      sh <= ach1 ? sh + (eh1 ? ONE : 32'd0) : (eh1 ? ONE : 32'd0);
    end
  end

  typedef struct {
    bit st; bit hd;
    int ax; int ah;
    bit ex; bit eh; bit acx; bit ach; bit bs; bit vl;
  } vec_t;

  vec_t tbl1[$], tblr[$], tbl2[$], sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(bit st, bit hd, int ax, int ah,
                              bit ex, bit eh, bit acx, bit ach, bit bs, bit vl);
    vec_t v;
    v.st = st; v.hd = hd; v.ax = ax; v.ah = ah;
    v.ex = ex; v.eh = eh; v.acx = acx; v.ach = ach; v.bs = bs; v.vl = vl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input vec_t e,
                          input logic [31:0] ax, input logic [31:0] ah,
                          input logic ex, input logic eh, input logic acx,
                          input logic ach, input logic bs, input logic vl);
    chk({tag, ".addr_x"}, ax, e.ax);
    chk({tag, ".addr_h"}, ah, e.ah);
    chk({tag, ".en_x"},   {31'd0, ex},  {31'd0, e.ex});
    chk({tag, ".en_h"},   {31'd0, eh},  {31'd0, e.eh});
    chk({tag, ".acc_x"},  {31'd0, acx}, {31'd0, e.acx});
    chk({tag, ".acc_h"},  {31'd0, ach}, {31'd0, e.ach});
    chk({tag, ".busy"},   {31'd0, bs},  {31'd0, e.bs});
    chk({tag, ".valid"},  {31'd0, vl},  {31'd0, e.vl});
  endtask

  // Drive one row, let an edge pass, then compare against the queued expectation.
  task automatic apply(input vec_t v, input bit sel, input string tag);
    vec_t e;
    @(negedge clk);
    if (sel) begin st2 = v.st; hd2 = v.hd; end
    else     begin st1 = v.st; hd1 = v.hd; end
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (sel) begin
      chk_outs(tag, e, 32'(ax2), 32'(ah2), ex2, eh2, acx2, ach2, b2, v2);
    end else begin
      chk_outs(tag, e, 32'(ax1), 32'(ah1), ex1, eh1, acx1, ach1, b1, v1);
      if (e.vl) chk({tag, ".presum"}, 32'(sx + sh), 32'd7 << FRAC);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t idle, zero, s0, s0_1;
    idle = mk(0,0, 0,0, 0,0,1,1, 0,0);
    zero = mk(0,0, 0,0, 0,0,0,0, 0,0);
    s0   = mk(1,0, 0,0, 1,1,0,0, 1,0);
    s0_1 = mk(0,0, 0,0, 1,1,0,0, 1,0);

    // DUT1: basic walk of the 4/3 vectors, then an idle cycle.
    tbl1.push_back(idle);
    tbl1.push_back(s0);
    tbl1.push_back(mk(0,0, 1,1, 1,1,1,1, 1,0));
    tbl1.push_back(mk(0,0, 2,2, 1,1,1,1, 1,0));
    tbl1.push_back(mk(0,0, 3,2, 1,0,1,1, 1,0));
    tbl1.push_back(mk(0,0, 3,2, 0,0,1,1, 1,1));
    tbl1.push_back(idle);
    // Two hold cycles after i=0, so o_valid comes two cycles later.
    tbl1.push_back(s0);
    tbl1.push_back(mk(0,1, 0,0, 0,0,1,1, 1,0));
    tbl1.push_back(mk(0,1, 0,0, 0,0,1,1, 1,0));
    tbl1.push_back(mk(0,0, 1,1, 1,1,1,1, 1,0));
    tbl1.push_back(mk(0,0, 2,2, 1,1,1,1, 1,0));
    tbl1.push_back(mk(0,0, 3,2, 1,0,1,1, 1,0));
    tbl1.push_back(mk(0,0, 3,2, 0,0,1,1, 1,1));
    tbl1.push_back(idle);
    // Back-to-back: a start in the o_valid cycle restarts at i=0.
    tbl1.push_back(s0);
    tbl1.push_back(mk(0,0, 1,1, 1,1,1,1, 1,0));
    tbl1.push_back(mk(0,0, 2,2, 1,1,1,1, 1,0));
    tbl1.push_back(mk(0,0, 3,2, 1,0,1,1, 1,0));
    tbl1.push_back(mk(0,0, 3,2, 0,0,1,1, 1,1));
    tbl1.push_back(s0);
    tbl1.push_back(mk(0,0, 1,1, 1,1,1,1, 1,0));
    tbl1.push_back(mk(0,0, 2,2, 1,1,1,1, 1,0));
    tbl1.push_back(mk(0,0, 3,2, 1,0,1,1, 1,0));
    tbl1.push_back(mk(0,0, 3,2, 0,0,1,1, 1,1));
    tbl1.push_back(idle);
    // A start during ACC is ignored, as is a hold during WAIT.
    tbl1.push_back(s0);
    tbl1.push_back(mk(1,0, 1,1, 1,1,1,1, 1,0));
    tbl1.push_back(mk(0,0, 2,2, 1,1,1,1, 1,0));
    tbl1.push_back(mk(0,0, 3,2, 1,0,1,1, 1,0));
    tbl1.push_back(mk(0,1, 3,2, 0,0,1,1, 1,1));
    tbl1.push_back(mk(0,1, 0,0, 0,0,1,1, 0,0));
    tbl1.push_back(idle);
    // A hold that lands on i=0 delays the load cycle.
    tbl1.push_back(mk(1,1, 0,0, 0,0,1,1, 1,0));
    tbl1.push_back(s0_1);
    tbl1.push_back(mk(0,0, 1,1, 1,1,1,1, 1,0));
    tbl1.push_back(mk(0,0, 2,2, 1,1,1,1, 1,0));
    tbl1.push_back(mk(0,0, 3,2, 1,0,1,1, 1,0));
    tbl1.push_back(mk(0,0, 3,2, 0,0,1,1, 1,1));
    tbl1.push_back(idle);

    // After the mid-operation reset: idle cycles, then a full evaluation.
    tblr.push_back(idle);
    tblr.push_back(idle);
    tblr.push_back(s0);
    tblr.push_back(mk(0,0, 1,1, 1,1,1,1, 1,0));
    tblr.push_back(mk(0,0, 2,2, 1,1,1,1, 1,0));
    tblr.push_back(mk(0,0, 3,2, 1,0,1,1, 1,0));
    tblr.push_back(mk(0,0, 3,2, 0,0,1,1, 1,1));
    tblr.push_back(idle);

    // DUT2: single-element vectors, LAT=3, then a back-to-back pair.
    tbl2.push_back(idle);
    tbl2.push_back(s0);
    tbl2.push_back(mk(0,0, 0,0, 0,0,1,1, 1,0));
    tbl2.push_back(mk(0,0, 0,0, 0,0,1,1, 1,0));
    tbl2.push_back(mk(0,0, 0,0, 0,0,1,1, 1,1));
    tbl2.push_back(idle);
    tbl2.push_back(s0);
    tbl2.push_back(mk(0,0, 0,0, 0,0,1,1, 1,0));
    tbl2.push_back(mk(0,0, 0,0, 0,0,1,1, 1,0));
    tbl2.push_back(mk(0,0, 0,0, 0,0,1,1, 1,1));
    tbl2.push_back(s0);
    tbl2.push_back(mk(0,0, 0,0, 0,0,1,1, 1,0));
    tbl2.push_back(mk(0,0, 0,0, 0,0,1,1, 1,0));
    tbl2.push_back(mk(0,0, 0,0, 0,0,1,1, 1,1));
    tbl2.push_back(idle);

    // Power-on reset: every output is 0 while reset is held.
    #1 rst = 1'b1;
    #2;
    chk_outs("rst.d1", zero, 32'(ax1), 32'(ah1), ex1, eh1, acx1, ach1, b1, v1);
    chk_outs("rst.d2", zero, 32'(ax2), 32'(ah2), ex2, eh2, acx2, ach2, b2, v2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl1.size(); i++)
      apply(tbl1[i], 1'b0, $sformatf("d1.r%0d", i));

    // Reset raised mid-ACC: outputs clear asynchronously and no o_valid follows.
    apply(s0, 1'b0, "abort.s0");
    apply(mk(0,0, 1,1, 1,1,1,1, 1,0), 1'b0, "abort.i1");
    apply(mk(0,0, 2,2, 1,1,1,1, 1,0), 1'b0, "abort.i2");
    @(negedge clk);
    st1 = 1'b0;
    hd1 = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk_outs("abort.rst", zero, 32'(ax1), 32'(ah1), ex1, eh1, acx1, ach1, b1, v1);
    #1 rst = 1'b0;

    for (int i = 0; i < tblr.size(); i++)
      apply(tblr[i], 1'b0, $sformatf("post.r%0d", i));

    for (int i = 0; i < tbl2.size(); i++)
      apply(tbl2[i], 1'b1, $sformatf("d2.r%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
